// File: rtl/qspi_fetch_pkg.sv
// Shared constants and state encoding for the quad-I/O (0xEB) cache-line fetch engine.
package qspi_fetch_pkg;

  localparam logic [7:0] CMD_QIO_READ = 8'hEB;

  localparam int CMD_CLKS  = 8;
  localparam int ADDR_CLKS = 6;
  localparam int MODE_CLKS = 2;

  // Wide enough for the longest phase (DATA at LW=1024 or a long dummy run)
  localparam int CNT_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_MODE,
    S_DUMMY,
    S_DATA,
    S_CSH
  } state_t;

  function automatic int data_clks(input int lw);
    return lw / 4;
  endfunction

endpackage

// File: rtl/qspi_line_shreg.sv
// Nibble-indexed line capture register: nibble n lands in byte n/2, high half first.
module qspi_line_shreg #(
  parameter int  LW = 256,
  localparam int IW = $clog2(LW / 4)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [3:0]    nibble,
  output logic [LW-1:0] line
);

  // Bit offset = 8*(idx/2) + (idx even ? 4 : 0)
  logic [IW+1:0] off;
  assign off = {idx[IW-1:1], ~idx[0], 2'b00};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      line <= '0;
    end else if (we) begin
      line[off +: 4] <= nibble;
    end
  end

endmodule

// File: rtl/qspi_line_fetch.sv
// Quad-I/O read engine: issues 0xEB + address + mode + dummy, then captures one cache line.
// state  | meaning
// IDLE   | csn high, waiting for start or a pending request
// CMD    | 0xEB on IO0, one bit per sck
// ADDR   | line-aligned 24-bit address, one nibble per sck
// MODE   | mode byte, high nibble first
// DUMMY  | turnaround clocks, all IOs released
// DATA   | capture LW/4 nibbles from di
// CSH    | csn high hold time before the next transaction
module qspi_line_fetch
  import qspi_fetch_pkg::*;
#(
  parameter int         LW        = 256,
  parameter int         DUMMY     = 4,
  parameter int         CSH_CYC   = 2,
  parameter logic [7:0] MODE_BYTE = 8'h00
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [23:0]   A,
  output logic [LW-1:0] D,
  output logic          done,
  output logic          busy,
  output logic          csn,
  output logic          sck,
  output logic [3:0]    doe,
  output logic [3:0]    dout,
  input  logic [3:0]    di
);

  localparam int          DCLKS      = data_clks(LW);
  localparam int          IW         = $clog2(DCLKS);
  localparam logic [23:0] ALIGN_MASK = 24'(LW / 8 - 1);

  function automatic state_t next_phase(input state_t s);
    state_t r;
    case (s)
      S_CMD:   r = S_ADDR;
      S_ADDR:  r = S_MODE;
      S_MODE:  r = (DUMMY > 0) ? S_DUMMY : S_DATA;
      default: r = S_DATA;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] phase_last(input state_t s);
    logic [CNT_W-1:0] r;
    case (s)
      S_CMD:   r = CNT_W'(CMD_CLKS - 1);
      S_ADDR:  r = CNT_W'(ADDR_CLKS - 1);
      S_MODE:  r = CNT_W'(MODE_CLKS - 1);
      S_DUMMY: r = CNT_W'(DUMMY - 1);
      default: r = CNT_W'(DCLKS - 1);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] phase_doe(input state_t s);
    logic [3:0] r;
    case (s)
      S_CMD:          r = 4'b0001;
      S_ADDR, S_MODE: r = 4'b1111;
      default:        r = 4'b0000;
    endcase
    return r;
  endfunction

  // Counter runs down, so the remaining-period count doubles as the MSB-first bit/nibble index
  function automatic logic [3:0] tx_nibble(input state_t s, input logic [2:0] c,
                                           input logic [23:0] a);
    logic [3:0] r;
    case (s)
      S_CMD:   r = {3'b000, CMD_QIO_READ[c]};
      S_ADDR:  r = a[{c, 2'b00} +: 4];
      S_MODE:  r = MODE_BYTE[{c[0], 2'b00} +: 4];
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_n, ph;
  logic [CNT_W-1:0] cnt_q, cnt_n, ph_cnt;
  logic [CNT_W-1:0] csh_q, csh_n;
  logic [23:0]      addr_q, addr_n, pend_addr_q, pend_addr_n;
  logic             pend_q, pend_n;
  logic             sck_n, csn_n, done_n, busy_n;
  logic [3:0]       doe_n, dout_n;
  logic             cap_we;
  logic [IW-1:0]    cap_idx;

  assign cap_idx = IW'(DCLKS - 1) - cnt_q[IW-1:0];

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    csh_n       = csh_q;
    addr_n      = addr_q;
    pend_n      = pend_q;
    pend_addr_n = pend_addr_q;
    sck_n       = sck;
    csn_n       = csn;
    done_n      = 1'b0;
    busy_n      = busy;
    doe_n       = doe;
    dout_n      = dout;
    cap_we      = 1'b0;
    ph          = state_q;
    ph_cnt      = cnt_q;

    if (state_q != S_IDLE && start) begin
      pend_n      = 1'b1;
      pend_addr_n = A & ~ALIGN_MASK;
    end

    case (state_q)
      S_IDLE: begin
        busy_n = 1'b0;
        if (pend_q || start) begin
          // A queued request goes first; a simultaneous new start becomes the next pending one
          addr_n      = pend_q ? pend_addr_q : (A & ~ALIGN_MASK);
          pend_n      = pend_q && start;
          pend_addr_n = A & ~ALIGN_MASK;
          state_n     = S_CMD;
          cnt_n       = phase_last(S_CMD);
          csn_n       = 1'b0;
          sck_n       = 1'b0;
          busy_n      = 1'b1;
          doe_n       = phase_doe(S_CMD);
          dout_n      = {3'b000, CMD_QIO_READ[7]};
        end
      end

      S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
        if (!sck) begin
          sck_n = 1'b1;
        end else begin
          sck_n  = 1'b0;
          cap_we = (state_q == S_DATA);
          if (cnt_q != '0) begin
            ph_cnt = cnt_q - 1'b1;
          end else if (state_q != S_DATA) begin
            ph     = next_phase(state_q);
            ph_cnt = phase_last(ph);
          end
          if (state_q == S_DATA && cnt_q == '0) begin
            state_n = S_CSH;
            csh_n   = CNT_W'(CSH_CYC - 1);
            csn_n   = 1'b1;
            doe_n   = 4'b0000;
            dout_n  = 4'h0;
            done_n  = 1'b1;
          end else begin
            state_n = ph;
            cnt_n   = ph_cnt;
            doe_n   = phase_doe(ph);
            dout_n  = tx_nibble(ph, ph_cnt[2:0], addr_q);
          end
        end
      end

      S_CSH: begin
        if (csh_q == '0) begin
          state_n = S_IDLE;
          busy_n  = pend_q || start;
        end else begin
          csh_n = csh_q - 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      csh_q       <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      sck         <= 1'b0;
      csn         <= 1'b1;
      done        <= 1'b0;
      busy        <= 1'b0;
      doe         <= 4'b0000;
      dout        <= 4'h0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      csh_q       <= csh_n;
      addr_q      <= addr_n;
      pend_q      <= pend_n;
      pend_addr_q <= pend_addr_n;
      sck         <= sck_n;
      csn         <= csn_n;
      done        <= done_n;
      busy        <= busy_n;
      doe         <= doe_n;
      dout        <= dout_n;
    end
  end

  qspi_line_shreg #(.LW(LW)) u_shreg (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .we     (cap_we),
    .idx    (cap_idx),
    .nibble (di),
    .line   (D)
  );

endmodule

// File: doc/qspi_line_fetch.md
Name: qspi_line_fetch

Overview:
- Quad-I/O (0xEB) fetch engine that reads one whole cache line from external SPI NOR flash into a parallel line buffer.
- Sits directly downstream of the AHB-Lite flash cache: the cache pulses start with the missing address, and this block returns the full LW-bit line plus a one-cycle done pulse.
- The block drives the flash pins (csn, sck, doe, do) and samples di.

Parameters:
LW, 256, line width in bits; power of 2, 64..1024
DUMMY, 4, dummy sck cycles after the mode byte
CSH_CYC, 2, minimum HCLK cycles csn stays high between transactions
MODE_BYTE, 8'h00, mode byte sent after address (0x00 = continuous-read disabled)

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle fetch request
A  in  24  byte address; low log2(LW/8) bits ignored (line-aligned)
D  out  LW  fetched line
done  out  1  one-cycle pulse, D valid
busy  out  1  high from accepted start until CSH complete
csn  out  1  flash chip select, active-low
sck  out  1  flash clock
doe  out  4  per-IO output enable
do  out  4  IO output data
di  in  4  IO input data

Behaviour:
- Reset values: csn=1, sck=0, doe=0, do=0, D=0, done=0, busy=0; state IDLE; pending=0.
- All outputs are registered.
- sck = HCLK/2; one sck period = a low cycle then a high cycle.
- do/doe change only on edges that leave sck low.
- di is sampled on the HCLK edge that takes sck 1->0.
- FSM: IDLE -> CMD -> ADDR -> MODE -> DUMMY -> DATA -> CSH -> IDLE.
- IDLE: start=1 latches the line-aligned A. Next cycle (cycle 1): csn=0, sck=0, state CMD.
- CMD: 8 sck periods; 0xEB MSB-first on do[0]; doe=4'b0001. IO2/IO3 are held high by board pull-ups.
- ADDR: 6 sck periods; A[23:0] nibble-wise MSB-first on do[3:0]; doe=4'b1111.
- MODE: 2 sck periods; MODE_BYTE high nibble first; doe=4'b1111.
- DUMMY: DUMMY sck periods; doe=0, do=0.
- DATA: LW/4 sck periods; doe=0.
  - Nibble n goes to byte k=n/2.
  - Even n -> D[8k+7:8k+4]; odd n -> D[8k+3:8k].
  - Byte k is the flash byte at base+k (little-endian words).
- End of transfer:
  - N = 16+DUMMY+LW/4 sck periods; the last sample happens at the edge ending cycle 2N.
  - On that edge csn->1, sck->0, doe->0, and done=1 for cycle 2N+1 only.
  - Defaults: N=84, done in cycle 169 after the start cycle 0.
- D is updated progressively during DATA. Value held after done, until the next DATA phase begins.
- CSH: csn held high for CSH_CYC cycles, counted from the cycle done is high.
- busy: 1 from cycle 1 through the last CSH cycle.
- start while busy (CMD..CSH): latched into pending with its address, overwriting any earlier pending request. The pending fetch begins the cycle after CSH ends, with identical timing. A start in the same cycle done is high is also latched.
- start in IDLE with pending=0: accepted immediately; no back-to-back restriction.
- Address wrap: A=24'hFFFFE0 with LW=256 fetches bytes 0xFFFFE0..0xFFFFFF; there is no wrap inside the block.
- Reset mid-transaction: all state returns to reset values asynchronously (csn=1 immediately); pending is cleared.

Decomposition:
- Package qspi_fetch_pkg:
  - CMD_QIO_READ=8'hEB
  - state enum (IDLE, CMD, ADDR, MODE, DUMMY, DATA, CSH)
  - phase lengths CMD_CLKS=8, ADDR_CLKS=6, MODE_CLKS=2
  - localparam DATA_CLKS(LW)=LW/4
- Sub-module qspi_line_shreg: LW-bit nibble-indexed capture register. Inputs: nibble, index, write enable. Maps nibble index to byte/half; keeps D byte-ordering logic isolated from the FSM.

Test Plan:
1. Reset, then idle 10 cycles -> csn=1, sck=0, doe=0, done=0, busy=0 throughout.
2. Flash model preloaded bytes[i]=i[7:0]; start with A=24'h000123 -> serial line shows 0xEB, address 0x000120, mode 0x00, 4 dummy clocks; done in cycle 169; D[31:0]=32'h23222120, D[255:224]=32'h3F3E3D3C.
3. Pin-level check of the same fetch -> exactly 84 sck rising edges while csn=0; doe=0001 for first 16 HCLK, 1111 for next 16, then 0000; do stable across every sck high phase.
4. Second start pulsed in cycle 100 of a fetch, A=24'h000400 -> first done in cycle 169; csn high for 2 cycles; second transaction starts; second done 171 cycles after the first; D[7:0]=8'h00 (byte 0x400).
5. Start at A=24'hFFFFE0 with model bytes[i]=~i[7:0] -> D[7:0]=8'h1F, D[255:248]=8'h00; no wrap artefacts.
6. HRESETn asserted in cycle 60 of a fetch -> csn=1 in the same cycle, done never pulses; a fresh start after reset release completes normally in 169 cycles.
